// File: rtl/lap_stopwatch_pkg.sv
// Shared types and constants for the BCD lap stopwatch.
package lap_stopwatch_pkg;

    // Top-level control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } state_t;

    // Modulus of each count digit, least significant first:
    // c1, c10, s1, s10, m1, m10.
    localparam int DIGIT_MOD [6] = '{10, 10, 10, 6, 10, 6};

    // Digit code the seven-segment decoder renders as an unlit digit.
    localparam logic [3:0] DEFAULT_BLANK_CODE = 4'hA;

endpackage : lap_stopwatch_pkg

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the count chain: counts 0..MOD-1 on inc, reports carry
// combinationally so a whole chain can ripple within a single tick cycle.
module bcd_digit_counter #(
    parameter int MOD = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    input  logic       hold_at_max,
    output logic [3:0] digit,
    output logic       carry
);

    localparam logic [3:0] MAX = 4'(MOD - 1);

    // Carry out fires whenever this digit is asked to step past its maximum.
    assign carry = inc && (digit == MAX);

    // Digit register: synchronous clear, increment with wrap, or freeze when
    // the whole chain is saturated.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!reset) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc && !hold_at_max) begin
            digit <= (digit == MAX) ? 4'd0 : digit + 4'd1;
        end
    end

endmodule : bcd_digit_counter

// File: rtl/lap_stopwatch.sv
// BCD stopwatch core MM:SS.cc with lap freeze, tick prescaler, wrap or
// saturate at 59:59.99, and leading-zero blanking of the minute-tens digit.
module lap_stopwatch
    import lap_stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 500000,
    parameter bit          SATURATE   = 1'b0,
    parameter bit          LEAD_BLANK = 1'b1,
    parameter logic [3:0]  BLANK_CODE = DEFAULT_BLANK_CODE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       lap_clear,
    output logic [3:0] m10,
    output logic [3:0] m1,
    output logic [3:0] s10,
    output logic [3:0] s1,
    output logic [3:0] c10,
    output logic [3:0] c1,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    localparam int          PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_t        state;
    state_t        next_state;
    logic [PW-1:0] presc;
    logic          counting;
    logic          tick;
    logic          count_clr;
    logic          terminal;
    logic          sat_hold;
    logic          disp_load;

    logic [3:0] cnt_c1, cnt_c10, cnt_s1, cnt_s10, cnt_m1, cnt_m10;
    logic       carry_c1, carry_c10, carry_s1, carry_s10, carry_m1, carry_m10;

    assign counting   = (state == RUN) || (state == LAP);
    assign tick       = counting && (presc == PRESC_MAX);
    assign count_clr  = (state == STOP) && lap_clear && !start_stop;
    assign running    = counting;
    assign lap_active = (state == LAP);

    // Next-state decode; start_stop always outranks lap_clear.
    always_comb begin
        // NOTE: next_state gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        next_state = state;
        case (state)
            IDLE: if (start_stop) next_state = RUN;
            RUN: begin
                if (start_stop)     next_state = STOP;
                else if (lap_clear) next_state = LAP;
            end
            LAP: begin
                if (start_stop)     next_state = STOP;
                else if (lap_clear) next_state = RUN;
            end
            STOP: begin
                if (start_stop)     next_state = RUN;
                else if (lap_clear) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Prescaler: runs in RUN/LAP, holds in STOP to keep the sub-tick
    // fraction, and is cleared in IDLE or by an explicit clear.
    always_ff @(posedge clk) begin
        if (!reset || state == IDLE || count_clr) begin
            presc <= '0;
        end else if (counting) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    // At 59:59.99 in saturate mode the whole chain freezes.
    assign terminal = (cnt_c1 == 4'd9) && (cnt_c10 == 4'd9) && (cnt_s1 == 4'd9) &&
                      (cnt_s10 == 4'd5) && (cnt_m1 == 4'd9) && (cnt_m10 == 4'd5);
    assign sat_hold = SATURATE && terminal;

    bcd_digit_counter #(.MOD(DIGIT_MOD[0])) u_c1 (
        .clk(clk), .reset(reset), .clr(count_clr), .inc(tick),
        .hold_at_max(sat_hold), .digit(cnt_c1), .carry(carry_c1)
    );
    bcd_digit_counter #(.MOD(DIGIT_MOD[1])) u_c10 (
        .clk(clk), .reset(reset), .clr(count_clr), .inc(carry_c1),
        .hold_at_max(sat_hold), .digit(cnt_c10), .carry(carry_c10)
    );
    bcd_digit_counter #(.MOD(DIGIT_MOD[2])) u_s1 (
        .clk(clk), .reset(reset), .clr(count_clr), .inc(carry_c10),
        .hold_at_max(sat_hold), .digit(cnt_s1), .carry(carry_s1)
    );
    bcd_digit_counter #(.MOD(DIGIT_MOD[3])) u_s10 (
        .clk(clk), .reset(reset), .clr(count_clr), .inc(carry_s1),
        .hold_at_max(sat_hold), .digit(cnt_s10), .carry(carry_s10)
    );
    bcd_digit_counter #(.MOD(DIGIT_MOD[4])) u_m1 (
        .clk(clk), .reset(reset), .clr(count_clr), .inc(carry_s10),
        .hold_at_max(sat_hold), .digit(cnt_m1), .carry(carry_m1)
    );
    bcd_digit_counter #(.MOD(DIGIT_MOD[5])) u_m10 (
        .clk(clk), .reset(reset), .clr(count_clr), .inc(carry_m1),
        .hold_at_max(sat_hold), .digit(cnt_m10), .carry(carry_m10)
    );

    // Sticky overflow: a tick at terminal count, in either mode.
    always_ff @(posedge clk) begin
        if (!reset || count_clr) overflow <= 1'b0;
        else if (carry_m10)      overflow <= 1'b1;
    end

    // The display is frozen only while staying in LAP; entering LAP captures
    // the count and leaving LAP releases it on the same edge.
    assign disp_load = !((state == LAP) && (next_state == LAP));

    // Display registers with minute-tens blanking applied at the output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            m10 <= LEAD_BLANK ? BLANK_CODE : 4'd0;
            m1  <= '0;
            s10 <= '0;
            s1  <= '0;
            c10 <= '0;
            c1  <= '0;
        end else if (disp_load) begin
            m10 <= (LEAD_BLANK && cnt_m10 == 4'd0) ? BLANK_CODE : cnt_m10;
            m1  <= cnt_m1;
            s10 <= cnt_s10;
            s1  <= cnt_s1;
            c10 <= cnt_c10;
            c1  <= cnt_c1;
        end
    end

endmodule : lap_stopwatch
